// File: rtl/vga_mouse_defs.sv
// Shared definitions for the VGA mouse path: screen and cursor geometry, the
// packet-assembler state encoding, the decoded byte0 header, and the clamp
// helper used by both position axes.
package vga_mouse_defs;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned CURSOR_W = 8;
  localparam int unsigned CURSOR_H = 11;

  // Largest cursor origin that keeps the whole cursor on screen.
  localparam int unsigned X_MAX_DEF = H_ACTIVE - CURSOR_W;
  localparam int unsigned Y_MAX_DEF = V_ACTIVE - CURSOR_H;

  // Signed working width for position arithmetic: wide enough for
  // (max position + |largest delta|) without wrapping.
  localparam int unsigned CalcW = 12;

  typedef enum logic [1:0] {
    StWaitB0 = 2'd0,
    StWaitB1 = 2'd1,
    StWaitB2 = 2'd2,
    StApply  = 2'd3
  } state_e;

  // Fields of PS/2 byte0 that are kept after capture; bit3 (always 1) is only
  // used to accept or reject the byte.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic btn_m;
    logic btn_r;
    logic btn_l;
  } hdr_t;

  function automatic logic signed [CalcW-1:0] clamp_pos(input logic signed [CalcW-1:0] v,
                                                        input logic signed [CalcW-1:0] max_v);
    if (v < 0) begin
      return '0;
    end else if (v > max_v) begin
      return max_v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/axis_accumulator.sv
// One cursor axis: holds the absolute position register, applies a signed
// PS/2 delta with clamping to [0, Max], and keeps a frame-latched copy for
// the painter so the cursor never moves mid-frame.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   delta_i        9-bit two's complement movement delta
//   negate_i       subtract the delta instead of adding it (PS/2 y is up)
//   ovf_i          overflow flag: treat the delta as zero
//   apply_i        update the position register this cycle
//   frame_tick_i   load the output from the (pre-edge) position register
//   out_o          frame-latched position
module axis_accumulator
  import vga_mouse_defs::*;
#(
  parameter int unsigned Width = 10,
  parameter int unsigned Init  = 320,
  parameter int unsigned Max   = 632
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic signed [8:0] delta_i,
  input  logic              negate_i,
  input  logic              ovf_i,
  input  logic              apply_i,
  input  logic              frame_tick_i,
  output logic [Width-1:0]  out_o
);

  logic [Width-1:0]        pos_q, pos_d;
  logic [Width-1:0]        out_q;
  logic signed [CalcW-1:0] delta_ext;
  logic signed [CalcW-1:0] pos_ext;
  logic signed [CalcW-1:0] sum;
  logic signed [CalcW-1:0] clamped;

  always_comb begin
    delta_ext = ovf_i ? '0 : {{(CalcW-9){delta_i[8]}}, delta_i};
    pos_ext   = signed'({{(CalcW-Width){1'b0}}, pos_q});
    sum       = negate_i ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
    clamped   = clamp_pos(sum, CalcW'(Max));
    pos_d     = apply_i ? Width'(clamped) : pos_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= Width'(Init);
      out_q <= Width'(Init);
    end else begin
      pos_q <= pos_d;
      if (frame_tick_i) begin
        out_q <= pos_q;
      end
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/mouse_position_tracker.sv
// Assembles 3-byte PS/2 mouse packets and turns them into an absolute,
// clamped cursor position plus button state. Positions reach the outputs only
// on frame_tick so the painter sees a stable cursor for the whole frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data, rx_valid   byte stream from the PS/2 receiver (one-cycle strobe)
//   frame_tick          one-cycle pulse at the start of vertical blanking
//   mouse_x, mouse_y    frame-latched cursor origin
//   btn_left/right/middle  buttons from the last applied packet
//   packet_valid        one-cycle pulse after a packet is applied
//   sync_err            one-cycle pulse on a rejected byte0 or a timeout
module mouse_position_tracker
  import vga_mouse_defs::*;
#(
  parameter int unsigned X_INIT         = 320,
  parameter int unsigned Y_INIT         = 240,
  parameter int unsigned X_MAX          = X_MAX_DEF,
  parameter int unsigned Y_MAX          = Y_MAX_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_tick,
  output logic [9:0] mouse_x,
  output logic [8:0] mouse_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       packet_valid,
  output logic       sync_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  hdr_t            hdr_q;
  logic [7:0]      dx_q, dy_q;
  logic [CntW-1:0] tmo_q;
  logic            btn_l_q, btn_r_q, btn_m_q;
  logic            pv_q, se_q;
  // A bad byte0 arriving in the APPLY cycle would collide with packet_valid;
  // its sync_err pulse is pushed one cycle later instead.
  logic            err_pend_q;
  logic            tmo_hit;
  logic            apply;

  assign tmo_hit = (tmo_q == CntLast) && !rx_valid;
  assign apply   = (state_q == StApply);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitB0;
      hdr_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      tmo_q      <= '0;
      btn_l_q    <= 1'b0;
      btn_r_q    <= 1'b0;
      btn_m_q    <= 1'b0;
      pv_q       <= 1'b0;
      se_q       <= err_pend_q & 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      pv_q       <= 1'b0;
      se_q       <= err_pend_q;
      err_pend_q <= 1'b0;
      unique case (state_q)
        // APPLY doubles as a WAIT_B0 cycle so a byte0 arriving right behind
        // the last byte of the previous packet is not lost.
        StWaitB0, StApply: begin
          tmo_q <= '0;
          if (apply) begin
            pv_q    <= 1'b1;
            btn_l_q <= hdr_q.btn_l;
            btn_r_q <= hdr_q.btn_r;
            btn_m_q <= hdr_q.btn_m;
          end
          state_q <= StWaitB0;
          if (rx_valid) begin
            if (rx_data[3]) begin
              hdr_q   <= '{y_ovf:  rx_data[7], x_ovf:  rx_data[6],
                           y_sign: rx_data[5], x_sign: rx_data[4],
                           btn_m:  rx_data[2], btn_r:  rx_data[1],
                           btn_l:  rx_data[0]};
              state_q <= StWaitB1;
            end else if (apply) begin
              err_pend_q <= 1'b1;
            end else begin
              se_q <= 1'b1;
            end
          end
        end
        StWaitB1: begin
          if (rx_valid) begin
            tmo_q   <= '0;
            dx_q    <= rx_data;
            state_q <= StWaitB2;
          end else if (tmo_hit) begin
            tmo_q   <= '0;
            se_q    <= 1'b1;
            state_q <= StWaitB0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StWaitB2: begin
          if (rx_valid) begin
            tmo_q   <= '0;
            dy_q    <= rx_data;
            state_q <= StApply;
          end else if (tmo_hit) begin
            tmo_q   <= '0;
            se_q    <= 1'b1;
            state_q <= StWaitB0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          tmo_q   <= '0;
          state_q <= StWaitB0;
        end
      endcase
    end
  end

  axis_accumulator #(
    .Width (10),
    .Init  (X_INIT),
    .Max   (X_MAX)
  ) u_axis_x (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .delta_i      ({hdr_q.x_sign, dx_q}),
    .negate_i     (1'b0),
    .ovf_i        (hdr_q.x_ovf),
    .apply_i      (apply),
    .frame_tick_i (frame_tick),
    .out_o        (mouse_x)
  );

  // Screen y grows downward while PS/2 y grows upward.
  axis_accumulator #(
    .Width (9),
    .Init  (Y_INIT),
    .Max   (Y_MAX)
  ) u_axis_y (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .delta_i      ({hdr_q.y_sign, dy_q}),
    .negate_i     (1'b1),
    .ovf_i        (hdr_q.y_ovf),
    .apply_i      (apply),
    .frame_tick_i (frame_tick),
    .out_o        (mouse_y)
  );

  assign btn_left     = btn_l_q;
  assign btn_right    = btn_r_q;
  assign btn_middle   = btn_m_q;
  assign packet_valid = pv_q;
  assign sync_err     = se_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker. A packet-level model (byte
// collection, integer position math with clamping, idle-gap counting) predicts
// every output each cycle; literal checks pin the model to hand-computed values.
module tb_mouse_position_tracker;

  localparam int unsigned TMO = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] mouse_x;
  logic [8:0] mouse_y;
  logic       btn_left, btn_right, btn_middle, packet_valid, sync_err;

  always #5 clk = ~clk;

  mouse_position_tracker #(
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_tick   (frame_tick),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_middle   (btn_middle),
    .packet_valid (packet_valid),
    .sync_err     (sync_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pv_seen = 0;
  int se_seen = 0;
  bit chk_en  = 1'b0;

  // Model state
  int         m_x, m_y, m_ox, m_oy;
  bit         m_l, m_r, m_m, m_pv, m_se;
  bit         m_apply, m_defer;
  int         m_cnt, m_gap;
  logic [7:0] m_pkt [3];

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_ox = 320; m_oy = 240;
    m_l = 0; m_r = 0; m_m = 0; m_pv = 0; m_se = 0;
    m_apply = 0; m_defer = 0; m_cnt = 0; m_gap = 0;
  endtask

  // Advance the model over one clock edge given the inputs held during it.
  task automatic model_step(input bit v, input logic [7:0] d, input bit tick);
    bit pv = 1'b0;
    bit se = m_defer;
    int dx, dy;
    m_defer = 1'b0;
    if (tick) begin
      m_ox = m_x;
      m_oy = m_y;
    end
    if (m_apply) begin
      dx = m_pkt[0][6] ? 0 : (m_pkt[0][4] ? int'(m_pkt[1]) - 256 : int'(m_pkt[1]));
      dy = m_pkt[0][7] ? 0 : (m_pkt[0][5] ? int'(m_pkt[2]) - 256 : int'(m_pkt[2]));
      m_x = clampi(m_x + dx, 632);
      m_y = clampi(m_y - dy, 469);
      m_l = m_pkt[0][0];
      m_r = m_pkt[0][1];
      m_m = m_pkt[0][2];
      pv = 1'b1;
    end
    if (v) begin
      m_gap = 0;
      if (m_cnt == 0 && !d[3]) begin
        if (m_apply) m_defer = 1'b1;
        else se = 1'b1;
      end else begin
        m_pkt[m_cnt] = d;
        m_cnt++;
      end
    end else if (m_cnt > 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        m_cnt = 0;
        m_gap = 0;
        se = 1'b1;
      end
    end
    m_apply = 1'b0;
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_apply = 1'b1;
    end
    m_pv = pv;
    m_se = se;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mouse_x", int'(mouse_x), m_ox);
      cmp("mouse_y", int'(mouse_y), m_oy);
      cmp("btn_left", int'(btn_left), int'(m_l));
      cmp("btn_right", int'(btn_right), int'(m_r));
      cmp("btn_middle", int'(btn_middle), int'(m_m));
      cmp("packet_valid", int'(packet_valid), int'(m_pv));
      cmp("sync_err", int'(sync_err), int'(m_se));
      cmp("pv_se_exclusive", int'(packet_valid && sync_err), 0);
      if (packet_valid) pv_seen++;
      if (sync_err) se_seen++;
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit tick);
    rx_valid   = v;
    rx_data    = d;
    frame_tick = tick;
    @(posedge clk);
    #1;
    if (rst_n) model_step(v, d, tick);
    rx_valid   = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    step(1'b1, b0, 1'b0); idle(1);
    step(1'b1, b1, 1'b0); idle(1);
    step(1'b1, b2, 1'b0); idle(2);
  endtask

  task automatic tick();
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv0, se0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    cmp("reset_x", int'(mouse_x), 320);
    cmp("reset_y", int'(mouse_y), 240);
    rst_n = 1'b1;
    idle(2);
    tick();
    cmp("reset_tick_x", int'(mouse_x), 320);
    cmp("reset_tick_y", int'(mouse_y), 240);
    cmp("reset_no_pulses", pv_seen + se_seen, 0);

    // Basic packet with left button; outputs wait for frame_tick
    send3(8'h09, 8'h05, 8'h03);
    cmp("p1_pre_tick_x", int'(mouse_x), 320);
    cmp("p1_btn_left", int'(btn_left), 1);
    cmp("p1_pv_count", pv_seen, 1);
    tick();
    cmp("p1_x", int'(mouse_x), 325);
    cmp("p1_y", int'(mouse_y), 237);

    // Walk to 630 then clamp at 632
    send3(8'h08, 8'hFF, 8'h00);
    send3(8'h08, 8'h32, 8'h00);
    tick();
    cmp("walk_x", int'(mouse_x), 630);
    send3(8'h08, 8'h0A, 8'h00);
    tick();
    cmp("clamp_xmax", int'(mouse_x), 632);

    // Negative deltas
    send3(8'h38, 8'hF6, 8'hF6);
    tick();
    cmp("neg_x", int'(mouse_x), 622);
    cmp("neg_y", int'(mouse_y), 247);

    // Clamp at y=0
    send3(8'h08, 8'h00, 8'hFF);
    send3(8'h08, 8'h00, 8'h05);
    tick();
    cmp("clamp_y0", int'(mouse_y), 0);

    // Overflow bits zero the affected axis
    pv0 = pv_seen;
    send3(8'h48, 8'h10, 8'h00);
    tick();
    cmp("xovf_x", int'(mouse_x), 622);
    cmp("xovf_pv", pv_seen - pv0, 1);
    send3(8'h8A, 8'h03, 8'h50);
    tick();
    cmp("yovf_x", int'(mouse_x), 625);
    cmp("yovf_y", int'(mouse_y), 0);
    cmp("yovf_btn_right", int'(btn_right), 1);

    // Resync on a byte0 without bit3
    se0 = se_seen;
    step(1'b1, 8'h00, 1'b0);
    idle(2);
    cmp("resync_err", se_seen - se0, 1);
    send3(8'h08, 8'h01, 8'h00);
    tick();
    cmp("resync_x", int'(mouse_x), 626);

    // Timeout drops the partial packet
    se0 = se_seen;
    step(1'b1, 8'h08, 1'b0); idle(1);
    step(1'b1, 8'h05, 1'b0);
    idle(TMO + 2);
    cmp("timeout_err", se_seen - se0, 1);
    send3(8'h08, 8'h02, 8'h00);
    tick();
    cmp("timeout_x", int'(mouse_x), 628);

    // Byte0 arriving in the APPLY cycle is kept
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h09, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    idle(2);
    tick();
    cmp("b2b_x", int'(mouse_x), 630);
    cmp("b2b_btn_left", int'(btn_left), 1);

    // Bad byte0 in the APPLY cycle still reports, but not alongside packet_valid
    se0 = se_seen;
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    idle(3);
    cmp("apply_bad_err", se_seen - se0, 1);

    // frame_tick in the APPLY cycle latches the old position
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    tick();
    cmp("apply_tick_old_x", int'(mouse_x), 631);
    tick();
    cmp("apply_tick_new_x", int'(mouse_x), 632);

    // Reset mid-packet
    step(1'b1, 8'h08, 1'b0); idle(1);
    step(1'b1, 8'h05, 1'b0); idle(1);
    rst_n = 1'b0;
    model_reset();
    idle(1);
    cmp("midrst_x", int'(mouse_x), 320);
    cmp("midrst_y", int'(mouse_y), 240);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send3(8'h08, 8'h01, 8'h00);
    tick();
    cmp("postrst_x", int'(mouse_x), 321);
    cmp("postrst_y", int'(mouse_y), 240);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
